// File: rtl/traffic_request_ctrl_if.sv
// Request-side signal bundle between the sensor/button front-end and its user.
// master drives sensors and light state; slave returns en, ped_wait, fault.
interface traffic_request_ctrl_if;
  logic       car_sense;
  logic       ped_btn;
  logic [2:0] state_in;
  logic       en;
  logic       ped_wait;
  logic       fault;

  modport master (
    output car_sense, ped_btn, state_in,
    input  en, ped_wait, fault
  );

  modport slave (
    input  car_sense, ped_btn, state_in,
    output en, ped_wait, fault
  );
endinterface

// File: rtl/traffic_request_ctrl.sv
// Request front-end for traffic_light: syncs/debounces car and ped inputs,
// gates en for one light cycle, then a hold-off gap; sticky watchdog fault.
// Ports: clk, rst (async active-low), bus (slave): car_sense, ped_btn,
// state_in in; en, ped_wait, fault out.
module traffic_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_GAP         = 16,
  parameter int unsigned MAX_SERVICE     = 64,
  parameter logic [2:0]  HOME_STATE      = 3'b100
) (
  input  logic clk,
  input  logic rst,
  traffic_request_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int WW = $clog2(MAX_SERVICE + 1);

  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] GMAX = GW'(MIN_GAP);
  localparam logic [WW-1:0] WMAX = WW'(MAX_SERVICE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    SERVE   = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  logic [1:0]    car_s_q, ped_s_q;
  logic [DW-1:0] car_cnt_q, car_cnt_d;
  logic [DW-1:0] ped_cnt_q, ped_cnt_d;
  logic          ped_deb_q;
  logic          ped_wait_q, ped_wait_d;
  logic          fault_q, fault_d;
  logic [GW-1:0] gap_q, gap_d, gap_nxt;
  logic [WW-1:0] wd_q, wd_d, wd_nxt;
  state_e        state_q, state_d;

  logic car_req, ped_deb, ped_rise, ped_clr;
  logic wd_hit, home;

  always_comb begin
    car_cnt_d = '0;
    ped_cnt_d = '0;
    if (car_s_q[1])
      car_cnt_d = (car_cnt_q == DMAX) ? car_cnt_q : car_cnt_q + DW'(1);
    if (ped_s_q[1])
      ped_cnt_d = (ped_cnt_q == DMAX) ? ped_cnt_q : ped_cnt_q + DW'(1);
  end

  assign car_req  = (car_cnt_q == DMAX);
  assign ped_deb  = (ped_cnt_q == DMAX);
  assign ped_rise = ped_deb & ~ped_deb_q;
  assign home     = (bus.state_in == HOME_STATE);

  // Saturating increments; no counter may wrap.
  assign gap_nxt = (gap_q == GMAX) ? gap_q : gap_q + GW'(1);
  assign wd_nxt  = (wd_q == WMAX) ? wd_q : wd_q + WW'(1);
  assign wd_hit  = (wd_nxt == WMAX);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    fault_d = fault_q;
    ped_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_d = '0;
        if (ped_wait_q | car_req) begin
          state_d = ARM;
          wd_d    = '0;
        end
      end
      ARM: begin
        wd_d = wd_nxt;
        if (wd_hit) begin
          fault_d = 1'b1;
          state_d = HOLDOFF;
          gap_d   = '0;
        end else if (!home) begin
          state_d = SERVE;
          ped_clr = 1'b1;
        end
      end
      SERVE: begin
        wd_d = wd_nxt;
        if (wd_hit) begin
          fault_d = 1'b1;
          state_d = HOLDOFF;
          gap_d   = '0;
        end else if (home) begin
          state_d = HOLDOFF;
          gap_d   = '0;
        end
      end
      HOLDOFF: begin
        gap_d = gap_nxt;
        if (gap_nxt == GMAX)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new press in the same cycle as the clear must survive.
  assign ped_wait_d = ped_rise | (ped_wait_q & ~ped_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_s_q    <= '0;
      ped_s_q    <= '0;
      car_cnt_q  <= '0;
      ped_cnt_q  <= '0;
      ped_deb_q  <= 1'b0;
      ped_wait_q <= 1'b0;
      fault_q    <= 1'b0;
      gap_q      <= '0;
      wd_q       <= '0;
      state_q    <= IDLE;
    end else begin
      car_s_q    <= {car_s_q[0], bus.car_sense};
      ped_s_q    <= {ped_s_q[0], bus.ped_btn};
      car_cnt_q  <= car_cnt_d;
      ped_cnt_q  <= ped_cnt_d;
      ped_deb_q  <= ped_deb;
      ped_wait_q <= ped_wait_d;
      fault_q    <= fault_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      state_q    <= state_d;
    end
  end

  assign bus.en       = (state_q == ARM) || (state_q == SERVE);
  assign bus.ped_wait = ped_wait_q;
  assign bus.fault    = fault_q;

endmodule

// File: doc/traffic_request_ctrl.md
# traffic_request_ctrl

Request front-end for `traffic_light`: synchronises and debounces a vehicle sensor and a pedestrian push-button, and drives the controller's `en` input. It holds `en` high for exactly one full light cycle per service, then enforces a hold-off gap before the next one. It sits directly upstream of `traffic_light`, takes that block's `state_out` back as `state_in`, and also drives the pedestrian "wait" lamp.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive high samples required before a synchronised input counts as asserted (≥1).
- `MIN_GAP`, 16: cycles `en` is held low after a service completes (≥1).
- `MAX_SERVICE`, 64: watchdog limit in cycles for one service (ARM+SERVE).
- `HOME_STATE`, 3'b100: `state_in` value meaning the light controller is at rest (main-road green).

Ports:
- `clk` input, 1: single clock; all flops rising-edge.
- `rst` input, 1: asynchronous, active-low reset.
- `car_sense` input, 1: side-road vehicle detector, asynchronous level.
- `ped_btn` input, 1: pedestrian button, asynchronous and bouncy.
- `state_in` input, 3: `state_out` of `traffic_light`, synchronous to `clk`.
- `en` output, 1: enable to `traffic_light`.
- `ped_wait` output, 1: pedestrian request pending lamp.
- `fault` output, 1: sticky watchdog flag.

## Operation
- **Synchronisers:** `car_sense` and `ped_btn` each pass through a 2-flop synchroniser.
- **Debounce:** each input has a counter saturating at `DEBOUNCE_CYCLES`.
  - Counter increments while the synchronised bit is 1 and clears to 0 when the bit is 0.
  - The debounced output is 1 while the counter equals `DEBOUNCE_CYCLES`.
- **Car request:** the debounced `car_sense` level; it is not latched.
- **Pedestrian latch (`ped_wait`):**
  - Set on a debounced `ped_btn` rising edge.
  - Cleared on the ARM→SERVE transition.
  - If a set and a clear occur in the same cycle, set wins.
  - Holding the button produces only one edge.
- **FSM**, 2-bit. `en` is decoded from the state register: it is 1 in ARM and SERVE, 0 otherwise.
  - **IDLE:** goes to ARM when `ped_wait` or the car request is 1.
  - **ARM:** goes to SERVE when `state_in != HOME_STATE`, i.e. the controller has left rest.
  - **SERVE:** goes to HOLDOFF when `state_in == HOME_STATE`.
  - **HOLDOFF:** gap counter counts 1..`MIN_GAP`; goes to IDLE on the cycle the count reaches `MIN_GAP`.
- **Watchdog:**
  - Counter cleared on IDLE→ARM and incremented every cycle in ARM or SERVE.
  - On reaching `MAX_SERVICE`: `fault` is set (sticky until reset), FSM goes to HOLDOFF, and the `ped_wait` latch is untouched.
  - The watchdog takes priority over a same-cycle ARM/SERVE transition.
- **Requests during SERVE/HOLDOFF:**
  - A press during SERVE re-sets `ped_wait`, and the request is served after HOLDOFF.
  - A car request still present at HOLDOFF exit causes immediate re-ARM.
- **Counter widths:** `$clog2(param+1)` bits. No counter ever wraps; all saturate or clear.

## Timing
- **Reset (asynchronous, `rst`=0):**
  - Outputs: `en`=0, `ped_wait`=0, `fault`=0.
  - Internal: FSM=IDLE, all counters and synchroniser flops cleared.
- **Reset deassertion:** first state change possible on the rising edge after `rst` goes high.
- **Reset mid-service:** `en` drops immediately (asynchronous); no pending request survives reset.
- **`ped_btn` latency:** input rises and is stable before edge 1; with D=`DEBOUNCE_CYCLES`:
  - debounced high after edge D+2;
  - `ped_wait` high after edge D+3;
  - `en` high after edge D+4.
  - With D=4: `ped_wait` high at edge 7, `en` high at edge 8.
- **Glitches:** a pulse shorter than D synchronised cycles produces no request.
- **`state_in`:** used unregistered; ARM→SERVE and SERVE→HOLDOFF each occur on the edge where the condition is first true.
- **Gap:** from `en` falling to earliest re-rise is exactly `MIN_GAP`+1 cycles.

## Test plan
- **Reset values:** `rst`=0 with random inputs → `en`, `ped_wait`, `fault` all 0. Release with inputs low → `en` stays 0 for 100 cycles.
- **Pedestrian service:** D=4, `ped_btn` high for 10 cycles → `ped_wait` at edge 7, `en` at edge 8. Model `state_in` leaving HOME at edge 12 → `ped_wait` cleared edge 12. `state_in` returning at edge 30 → `en` low after edge 30, stays low 16 cycles.
- **Bounce rejection:** `ped_btn` pulses of 3 cycles separated by 1-cycle lows, repeated 20 times → `ped_wait` never set, `en` never high.
- **Car level plus re-arm:** `car_sense` held high continuously → repeated services with exactly `MIN_GAP`+1 low cycles of `en` between them. Drop `car_sense` during SERVE → return to IDLE after HOLDOFF.
- **Press during SERVE:** press during SERVE → `ped_wait`=1 through HOLDOFF, then `en` re-asserts on the cycle after HOLDOFF ends.
- **Watchdog:** `state_in` held at HOME with request pending → `fault`=1 and `en`=0 after 64 cycles in ARM. `fault` stays 1 across later normal services until `rst` is pulsed.
